// File: rtl/mac_pkg.sv
// Shared types and constants for the FMA writeback/fcsr stage.
// Rounding modes, fflags bit positions, CSR addresses and the buffered writeback entry.
package mac_pkg;

    localparam int MAC_XLEN    = 32;
    localparam int MAC_RM      = 3;
    localparam int MAC_REGADDR = 5;

    localparam logic [11:0] CSR_FFLAGS = 12'h001;
    localparam logic [11:0] CSR_FRM    = 12'h002;
    localparam logic [11:0] CSR_FCSR   = 12'h003;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef struct packed {
        logic [MAC_REGADDR-1:0] rd;
        logic [MAC_XLEN-1:0]    data;
        logic [4:0]             flags;
    } wb_entry_t;

endpackage

// File: rtl/mac_wb_fifo.sv
// 2-deep valid/ready FIFO; data pushed at edge N is visible at the output in cycle N+1.
// in_rdy_o drops only when both slots are full; the head stays stable while out_rdy_i is low.
module mac_wb_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_vld_i,
    output logic         in_rdy_o,
    input  logic [W-1:0] in_dat_i,
    output logic         out_vld_o,
    input  logic         out_rdy_i,
    output logic [W-1:0] out_dat_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   cnt_q, cnt_d;
    logic         push, pop;

    assign in_rdy_o  = (cnt_q != 2'd2);
    assign out_vld_o = (cnt_q != 2'd0);
    assign out_dat_o = out_vld_o ? mem_q[rd_ptr_q] : '0;
    assign push      = in_vld_i & in_rdy_o;
    assign pop       = out_vld_o & out_rdy_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Payload needs no reset: the output is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_dat_i;
    end

endmodule

// File: rtl/mac_fcsr_wb.sv
// FMA result buffer to FP writeback, plus fflags/frm CSRs; one cycle push-to-output latency.
// mac_ready_o drops when 2 results wait; flags accrue only when a result retires to writeback.
module mac_fcsr_wb
    import mac_pkg::*;
#(
    parameter int          PARM_XLEN       = MAC_XLEN,
    parameter int          PARM_RM         = MAC_RM,
    parameter int          PARM_REGADDR    = MAC_REGADDR,
    parameter logic [11:0] PARM_CSR_FFLAGS = CSR_FFLAGS,
    parameter logic [11:0] PARM_CSR_FRM    = CSR_FRM,
    parameter logic [11:0] PARM_CSR_FCSR   = CSR_FCSR
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mac_valid_i,
    output logic                    mac_ready_o,
    input  logic [PARM_REGADDR-1:0] mac_rd_i,
    input  logic [PARM_XLEN-1:0]    Result_i,
    input  logic                    NV_i,
    input  logic                    OF_i,
    input  logic                    UF_i,
    input  logic                    NX_i,
    output logic                    wb_valid_o,
    input  logic                    wb_ready_i,
    output logic [PARM_REGADDR-1:0] wb_rd_o,
    output logic [PARM_XLEN-1:0]    wb_data_o,
    input  logic                    csr_we_i,
    input  logic [11:0]             csr_addr_i,
    input  logic [PARM_XLEN-1:0]    csr_wdata_i,
    output logic [PARM_XLEN-1:0]    csr_rdata_o,
    output logic [PARM_RM-1:0]      frm_o,
    output logic                    frm_illegal_o
);

    localparam int EW = $bits(wb_entry_t);

    wb_entry_t         push_ent, head_ent;
    logic [EW-1:0]     head_raw;
    logic              pop;
    logic              wr_fflags, wr_frm, wr_fcsr;
    logic [4:0]        fflags_q, fflags_d;
    logic [PARM_RM-1:0] frm_q, frm_d;
    logic              unused_wdata;

    always_comb begin
        push_ent                = '0;
        push_ent.rd             = mac_rd_i;
        push_ent.data           = Result_i;
        push_ent.flags[FLAG_NV] = NV_i;
        push_ent.flags[FLAG_DZ] = 1'b0;
        push_ent.flags[FLAG_OF] = OF_i;
        push_ent.flags[FLAG_UF] = UF_i;
        push_ent.flags[FLAG_NX] = NX_i;
    end

    mac_wb_fifo #(.W(EW)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld_i  (mac_valid_i),
        .in_rdy_o  (mac_ready_o),
        .in_dat_i  (push_ent),
        .out_vld_o (wb_valid_o),
        .out_rdy_i (wb_ready_i),
        .out_dat_o (head_raw)
    );

    assign head_ent  = wb_entry_t'(head_raw);
    assign wb_rd_o   = head_ent.rd;
    assign wb_data_o = head_ent.data;
    assign pop       = wb_valid_o & wb_ready_i;

    assign wr_fflags = csr_we_i & (csr_addr_i == PARM_CSR_FFLAGS);
    assign wr_frm    = csr_we_i & (csr_addr_i == PARM_CSR_FRM);
    assign wr_fcsr   = csr_we_i & (csr_addr_i == PARM_CSR_FCSR);

    // A CSR write replaces the base; a retiring result still ORs its flags on top.
    always_comb begin
        fflags_d = fflags_q;
        frm_d    = frm_q;
        if (wr_fflags || wr_fcsr) fflags_d = csr_wdata_i[4:0];
        if (pop)                  fflags_d = fflags_d | head_ent.flags;
        if (wr_frm)               frm_d = csr_wdata_i[2:0];
        else if (wr_fcsr)         frm_d = csr_wdata_i[7:5];
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            fflags_q <= 5'd0;
            frm_q    <= RM_RNE;
        end else begin
            fflags_q <= fflags_d;
            frm_q    <= frm_d;
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            PARM_CSR_FFLAGS: csr_rdata_o[4:0] = fflags_q;
            PARM_CSR_FRM:    csr_rdata_o[2:0] = frm_q;
            PARM_CSR_FCSR:   csr_rdata_o[7:0] = {frm_q, fflags_q};
            default:         csr_rdata_o = '0;
        endcase
    end

    assign frm_o         = frm_q;
    assign frm_illegal_o = (frm_q > RM_RMM);
    assign unused_wdata  = ^csr_wdata_i[PARM_XLEN-1:8];

endmodule

// File: tb/tb_mac_fcsr_wb.sv
// Bench for mac_fcsr_wb: vector table, hand sequences, and a negedge scoreboard/model.
module tb_mac_fcsr_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mac_valid_i;
    logic        mac_ready_o;
    logic [4:0]  mac_rd_i;
    logic [31:0] Result_i;
    logic        NV_i, OF_i, UF_i, NX_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic [2:0]  frm_o;
    logic        frm_illegal_o;

    int total = 0;
    int bad   = 0;

    mac_fcsr_wb dut (
        .clk(clk), .rst_n(rst_n),
        .mac_valid_i(mac_valid_i), .mac_ready_o(mac_ready_o), .mac_rd_i(mac_rd_i),
        .Result_i(Result_i), .NV_i(NV_i), .OF_i(OF_i), .UF_i(UF_i), .NX_i(NX_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i),
        .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o), .frm_o(frm_o),
        .frm_illegal_o(frm_illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  flags;
    } sb_t;

    sb_t      sb[$];
    int       m_cnt = 0;
    logic [4:0] m_ff = '0;
    logic [2:0] m_frm = '0;
    bit       m_on = 0;

    always @(negedge clk) begin
        logic       m_push, m_pop;
        logic [4:0] base, pflags;
        logic [31:0] exp_rd;
        sb_t        e;
        if (m_on) begin
            check("sb_mac_ready", mac_ready_o, m_cnt != 2);
            check("sb_wb_valid", wb_valid_o, m_cnt != 0);
            check("sb_frm", frm_o, m_frm);
            check("sb_frm_illegal", frm_illegal_o, m_frm >= 3'd5);
            case (csr_addr_i)
                12'h001: exp_rd = {27'b0, m_ff};
                12'h002: exp_rd = {29'b0, m_frm};
                12'h003: exp_rd = {24'b0, m_frm, m_ff};
                default: exp_rd = 32'h0;
            endcase
            check("sb_csr_rdata", csr_rdata_o, exp_rd);
        end
        if (rst_n) begin
            sb.delete();
            m_cnt = 0; m_ff = '0; m_frm = '0; m_on = 1;
        end else if (m_on) begin
            m_push = mac_valid_i && (m_cnt != 2);
            m_pop  = (m_cnt != 0) && wb_ready_i;
            pflags = '0;
            if (m_pop) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL sb_pop_empty: got pop want none");
                end else begin
                    e = sb.pop_front();
                    check("sb_wb_rd", wb_rd_o, e.rd);
                    check("sb_wb_data", wb_data_o, e.data);
                    pflags = e.flags;
                end
            end
            base = m_ff;
            if (csr_we_i && (csr_addr_i == 12'h001 || csr_addr_i == 12'h003)) base = csr_wdata_i[4:0];
            m_ff = base | pflags;
            if (csr_we_i && csr_addr_i == 12'h002) m_frm = csr_wdata_i[2:0];
            else if (csr_we_i && csr_addr_i == 12'h003) m_frm = csr_wdata_i[7:5];
            if (m_push) begin
                e.rd = mac_rd_i; e.data = Result_i;
                e.flags = {NV_i, 1'b0, OF_i, UF_i, NX_i};
                sb.push_back(e);
            end
            m_cnt = m_cnt + int'(m_push) - int'(m_pop);
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        bit          v;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [3:0]  fl;     // {NV, OF, UF, NX}
        bit          wr;
        bit          we;
        logic [11:0] a;
        logic [31:0] wd;
        bit          e_vld;
        logic [31:0] e_dat;
        bit          e_rdy;
        logic [31:0] e_rdata;
        logic [2:0]  e_frm;
    } vec_t;

    vec_t vt[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mac_valid_i = 0; mac_rd_i = '0; Result_i = '0;
        {NV_i, OF_i, UF_i, NX_i} = 4'b0;
        csr_we_i = 0; csr_wdata_i = '0;
    endtask

    task automatic drive_mac(input bit v, input logic [4:0] rd, input logic [31:0] d, input logic [3:0] fl);
        mac_valid_i = v; mac_rd_i = rd; Result_i = d;
        {NV_i, OF_i, UF_i, NX_i} = fl;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit c_taken;
        int k;
        //           v  rd  data          fl     wr we addr    wdata        vld dat           rdy rdata       frm
        vt[0]  = '{0, 0, 32'h0,        4'b0000, 0, 0, 12'h003, 32'h0,        0, 32'h0,        1, 32'h0,  3'd0};
        vt[1]  = '{1, 3, 32'h3F800000, 4'b0001, 1, 0, 12'h001, 32'h0,        0, 32'h0,        1, 32'h0,  3'd0};
        vt[2]  = '{0, 0, 32'h0,        4'b0000, 1, 0, 12'h001, 32'h0,        1, 32'h3F800000, 1, 32'h0,  3'd0};
        vt[3]  = '{0, 0, 32'h0,        4'b0000, 1, 0, 12'h001, 32'h0,        0, 32'h0,        1, 32'h1,  3'd0};
        vt[4]  = '{1, 7, 32'hAAAA0001, 4'b0100, 1, 0, 12'h002, 32'h0,        0, 32'h0,        1, 32'h0,  3'd0};
        vt[5]  = '{1, 8, 32'hBBBB0002, 4'b0010, 1, 0, 12'h001, 32'h0,        1, 32'hAAAA0001, 1, 32'h1,  3'd0};
        vt[6]  = '{1, 9, 32'hCCCC0003, 4'b1000, 1, 0, 12'h001, 32'h0,        1, 32'hBBBB0002, 1, 32'h5,  3'd0};
        vt[7]  = '{0, 0, 32'h0,        4'b0000, 1, 0, 12'h001, 32'h0,        1, 32'hCCCC0003, 1, 32'h7,  3'd0};
        vt[8]  = '{0, 0, 32'h0,        4'b0000, 1, 0, 12'h001, 32'h0,        0, 32'h0,        1, 32'h17, 3'd0};
        vt[9]  = '{0, 0, 32'h0,        4'b0000, 1, 1, 12'h001, 32'h0,        0, 32'h0,        1, 32'h17, 3'd0};
        vt[10] = '{0, 0, 32'h0,        4'b0000, 1, 0, 12'h001, 32'h0,        0, 32'h0,        1, 32'h0,  3'd0};
        vt[11] = '{0, 0, 32'h0,        4'b0000, 1, 1, 12'h002, 32'h5,        0, 32'h0,        1, 32'h0,  3'd0};
        vt[12] = '{0, 0, 32'h0,        4'b0000, 1, 0, 12'h002, 32'h0,        0, 32'h0,        1, 32'h5,  3'd5};
        vt[13] = '{0, 0, 32'h0,        4'b0000, 1, 1, 12'h002, 32'h4,        0, 32'h0,        1, 32'h5,  3'd5};
        vt[14] = '{0, 0, 32'h0,        4'b0000, 1, 0, 12'h003, 32'h0,        0, 32'h0,        1, 32'h80, 3'd4};
        vt[15] = '{0, 0, 32'h0,        4'b0000, 1, 1, 12'h004, 32'hFFFFFFFF, 0, 32'h0,        1, 32'h0,  3'd4};
        vt[16] = '{0, 0, 32'h0,        4'b0000, 1, 0, 12'h003, 32'h0,        0, 32'h0,        1, 32'h80, 3'd4};

        idle();
        wb_ready_i = 0; csr_addr_i = 12'h003; rst_n = 1;
        tick(); tick();
        rst_n = 0;
        #2;
        check("rst_mac_ready", mac_ready_o, 1);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_wb_rd", wb_rd_o, 0);
        check("rst_wb_data", wb_data_o, 0);
        check("rst_frm", frm_o, 0);
        check("rst_frm_illegal", frm_illegal_o, 0);
        check("rst_fcsr_read", csr_rdata_o, 0);

        for (int i = 0; i < 17; i++) begin
            tick();
            drive_mac(vt[i].v, vt[i].rd, vt[i].d, vt[i].fl);
            wb_ready_i = vt[i].wr; csr_we_i = vt[i].we;
            csr_addr_i = vt[i].a; csr_wdata_i = vt[i].wd;
            #2;
            check($sformatf("vec%0d_wb_valid", i), wb_valid_o, vt[i].e_vld);
            check($sformatf("vec%0d_wb_data", i), wb_data_o, vt[i].e_dat);
            check($sformatf("vec%0d_mac_ready", i), mac_ready_o, vt[i].e_rdy);
            check($sformatf("vec%0d_rdata", i), csr_rdata_o, vt[i].e_rdata);
            check($sformatf("vec%0d_frm", i), frm_o, vt[i].e_frm);
            check($sformatf("vec%0d_frm_illegal", i), frm_illegal_o, vt[i].e_frm >= 3'd5);
        end

        // simultaneous fcsr write and retire of a UF result
        tick(); idle(); wb_ready_i = 0;
        drive_mac(1, 5'd4, 32'h12345678, 4'b0010);
        tick(); idle(); wb_ready_i = 1;
        csr_we_i = 1; csr_addr_i = 12'h003; csr_wdata_i = 32'h0000_0060;
        tick(); idle(); wb_ready_i = 0; csr_addr_i = 12'h001;
        #2;
        check("wr_retire_frm", frm_o, 3'b011);
        check("wr_retire_fflags", csr_rdata_o, 32'h2);

        // backpressure: A, B fill the buffer, C is held
        drive_mac(1, 5'd10, 32'hA0A0A0A0, 4'b0000);
        tick(); drive_mac(1, 5'd11, 32'hB1B1B1B1, 4'b0000);
        tick(); drive_mac(1, 5'd12, 32'hC2C2C2C2, 4'b0000);
        #2;
        check("bp_full_ready", mac_ready_o, 0);
        check("bp_head_a", wb_data_o, 32'hA0A0A0A0);
        for (int j = 0; j < 3; j++) begin
            tick(); #2;
            check("bp_hold_ready", mac_ready_o, 0);
            check("bp_hold_data", wb_data_o, 32'hA0A0A0A0);
            check("bp_hold_rd", wb_rd_o, 5'd10);
        end
        tick(); wb_ready_i = 1;
        c_taken = 0;
        for (k = 0; k < 8 && !c_taken; k++) begin
            #2;
            if (mac_ready_o) c_taken = 1;
            tick();
        end
        mac_valid_i = 0;
        check("bp_c_accepted", c_taken, 1);
        k = 0;
        while (sb.size() != 0 && k < 10) begin tick(); k++; end
        check("bp_drained", sb.size(), 0);

        // reset while full and with sticky flags set
        wb_ready_i = 0; csr_we_i = 1; csr_addr_i = 12'h001; csr_wdata_i = 32'h1F;
        drive_mac(1, 5'd20, 32'hDEAD0001, 4'b1000);
        tick(); csr_we_i = 0; drive_mac(1, 5'd21, 32'hDEAD0002, 4'b1000);
        tick(); drive_mac(1, 5'd22, 32'hDEAD0003, 4'b1000);
        #2;
        check("prerst_full", mac_ready_o, 0);
        check("prerst_fflags", csr_rdata_o, 32'h1F);
        wb_ready_i = 1; rst_n = 1;
        tick(); rst_n = 0; idle(); wb_ready_i = 0;
        #2;
        check("midrst_wb_valid", wb_valid_o, 0);
        check("midrst_fflags", csr_rdata_o, 0);
        check("midrst_mac_ready", mac_ready_o, 1);
        check("midrst_frm", frm_o, 0);
        csr_addr_i = 12'h003;
        #1;
        check("midrst_fcsr", csr_rdata_o, 0);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
